// File: rtl/front_panel_control.sv
// Front-panel run/step/halt controller: button edge-detect, acknowledge handshake and CPU enable FSM.
// Optional completed-instruction counter (instrCount/countClear) built only when FRONT_PANEL_COUNT_EN is defined.
module front_panel_control #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   runPressed,
    input  logic                   stepPressed,
    input  logic                   haltPressed,
    input  logic                   cpuHalted,
    input  logic                   cycleDone,
`ifdef FRONT_PANEL_COUNT_EN
    input  logic                   countClear,
    output logic [COUNT_WIDTH-1:0] instrCount,
`endif
    output logic                   runAck,
    output logic                   stepAck,
    output logic                   haltAck,
    output logic                   cpuEnable,
    output logic                   running
);

    localparam int unsigned N_BTN = 3;

    typedef enum logic [1:0] {
        S_HALTED   = 2'd0,
        S_RUNNING  = 2'd1,
        S_STEPPING = 2'd2
    } state_t;

    if (COUNT_WIDTH == 0) begin : g_bad_width
        $error("front_panel_control: COUNT_WIDTH must be at least 1");
    end

    // Button order in the packed vectors: [0]=run, [1]=step, [2]=halt.
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_accept;
    logic [N_BTN-1:0] r_prev;
    logic [N_BTN-1:0] r_ack;
    state_t           r_state;
    logic             r_cpu_en;
    logic             r_running;

    assign w_press  = {haltPressed, stepPressed, runPressed};
    assign w_accept = w_press & ~r_prev;

    // Rising-edge acceptance and ack hold until the button is seen released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
            r_ack  <= '0;
        end else begin
            r_prev <= w_press;
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (w_accept[i]) begin
                    r_ack[i] <= 1'b1;
                end else if (!w_press[i]) begin
                    r_ack[i] <= 1'b0;
                end
            end
        end
    end

    // Mode FSM; halt beats step beats run when accepted together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_HALTED;
            r_cpu_en  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                S_HALTED: begin
                    if (!w_accept[2] && !cpuHalted) begin
                        if (w_accept[1]) begin
                            r_state  <= S_STEPPING;
                            r_cpu_en <= 1'b1;
                        end else if (w_accept[0]) begin
                            r_state   <= S_RUNNING;
                            r_cpu_en  <= 1'b1;
                            r_running <= 1'b1;
                        end
                    end
                end
                S_RUNNING: begin
                    if (w_accept[2] || cpuHalted) begin
                        r_state   <= S_HALTED;
                        r_cpu_en  <= 1'b0;
                        r_running <= 1'b0;
                    end
                end
                S_STEPPING: begin
                    if (w_accept[2] || cpuHalted || cycleDone) begin
                        r_state  <= S_HALTED;
                        r_cpu_en <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_HALTED;
                    r_cpu_en  <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign runAck    = r_ack[0];
    assign stepAck   = r_ack[1];
    assign haltAck   = r_ack[2];
    assign cpuEnable = r_cpu_en;
    assign running   = r_running;

`ifdef FRONT_PANEL_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_count;

    // Counts instructions retired while the CPU was enabled; clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (countClear) begin
            r_count <= '0;
        end else if (cycleDone && r_cpu_en) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

    assign instrCount = r_count;
`endif

endmodule

// File: tb/tb_front_panel_control.sv
// Randomized self-checking bench for front_panel_control against a mode-level reference model.
// Counter checks are active when FRONT_PANEL_COUNT_EN is defined.
module tb_front_panel_control;

    localparam int unsigned CW     = 4;
    localparam int          M_HALT = 0;
    localparam int          M_RUN  = 1;
    localparam int          M_STEP = 2;

    logic          clock;
    logic          reset;
    logic          runPressed;
    logic          stepPressed;
    logic          haltPressed;
    logic          cpuHalted;
    logic          cycleDone;
    logic          countClear;
    logic          runAck;
    logic          stepAck;
    logic          haltAck;
    logic          cpuEnable;
    logic          running;
`ifdef FRONT_PANEL_COUNT_EN
    logic [CW-1:0] instrCount;
`endif

    int       n_checks;
    int       n_fail;
    int       m_mode;
    bit [2:0] m_prev;
    bit [2:0] m_ack;
    int       m_cnt;

    front_panel_control #(.COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .runPressed  (runPressed),
        .stepPressed (stepPressed),
        .haltPressed (haltPressed),
        .cpuHalted   (cpuHalted),
        .cycleDone   (cycleDone),
`ifdef FRONT_PANEL_COUNT_EN
        .countClear  (countClear),
        .instrCount  (instrCount),
`endif
        .runAck      (runAck),
        .stepAck     (stepAck),
        .haltAck     (haltAck),
        .cpuEnable   (cpuEnable),
        .running     (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a press counts on its first high sample; halt dominates; modes imply the outputs.
    task automatic model_update();
        bit [2:0] p;
        bit [2:0] acc;
        p   = {haltPressed, stepPressed, runPressed};
        acc = p & ~m_prev;
        if (countClear)
            m_cnt = 0;
        else if (cycleDone && m_mode != M_HALT)
            m_cnt = (m_cnt + 1) % (1 << CW);
        if (acc[2]) begin
            m_mode = M_HALT;
        end else if (m_mode == M_HALT) begin
            if (!cpuHalted && acc[1])      m_mode = M_STEP;
            else if (!cpuHalted && acc[0]) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (cpuHalted) m_mode = M_HALT;
        end else begin
            if (cpuHalted || cycleDone) m_mode = M_HALT;
        end
        for (int i = 0; i < 3; i++) begin
            if (acc[i])     m_ack[i] = 1'b1;
            else if (!p[i]) m_ack[i] = 1'b0;
        end
        m_prev = p;
    endtask

    task automatic compare_outputs();
        check_eq("cpuEnable", 32'(cpuEnable), 32'(m_mode != M_HALT));
        check_eq("running",   32'(running),   32'(m_mode == M_RUN));
        check_eq("runAck",    32'(runAck),    32'(m_ack[0]));
        check_eq("stepAck",   32'(stepAck),   32'(m_ack[1]));
        check_eq("haltAck",   32'(haltAck),   32'(m_ack[2]));
`ifdef FRONT_PANEL_COUNT_EN
        check_eq("instrCount", 32'(instrCount), 32'(m_cnt));
`endif
    endtask

    task automatic cycle();
        @(posedge clock);
        model_update();
        @(negedge clock);
        compare_outputs();
    endtask

    // Called at a falling edge: reset asserts between edges and is checked before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_cpuEnable", 32'(cpuEnable), 32'd0);
        check_eq("rst_running",   32'(running),   32'd0);
        check_eq("rst_acks",      32'({haltAck, stepAck, runAck}), 32'd0);
`ifdef FRONT_PANEL_COUNT_EN
        check_eq("rst_instrCount", 32'(instrCount), 32'd0);
`endif
        m_mode = M_HALT;
        m_prev = '0;
        m_ack  = '0;
        m_cnt  = 0;
        @(negedge clock);
        reset = 1'b0;
        compare_outputs();
    endtask

    task automatic clear_inputs();
        runPressed  = 1'b0;
        stepPressed = 1'b0;
        haltPressed = 1'b0;
        cpuHalted   = 1'b0;
        cycleDone   = 1'b0;
        countClear  = 1'b0;
    endtask

    initial begin
        int en_cycles;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_inputs();
        m_mode = M_HALT;
        m_prev = '0;
        m_ack  = '0;
        m_cnt  = 0;
        @(negedge clock);
        compare_outputs();
        reset = 1'b0;

        // Run held 5 cycles: one transition, ack drops one cycle after release.
        runPressed = 1'b1;
        cycle();
        check_eq("run_enable_latency", 32'(cpuEnable), 32'd1);
        for (int i = 0; i < 4; i++) cycle();
        runPressed = 1'b0;
        cycle();
        check_eq("run_ack_release", 32'(runAck), 32'd0);
        check_eq("run_still_running", 32'(running), 32'd1);

        // Single step with cycleDone arriving on the fifth edge.
        do_reset();
        en_cycles   = 0;
        stepPressed = 1'b1;
        cycle(); en_cycles += int'(cpuEnable);
        stepPressed = 1'b0;
        cycle(); en_cycles += int'(cpuEnable);
        cycle(); en_cycles += int'(cpuEnable);
        cycle(); en_cycles += int'(cpuEnable);
        cycleDone = 1'b1;
        cycle(); en_cycles += int'(cpuEnable);
        cycleDone = 1'b0;
        cycle(); en_cycles += int'(cpuEnable);
        check_eq("step_enable_cycles", 32'(en_cycles), 32'd4);
`ifdef FRONT_PANEL_COUNT_EN
        check_eq("step_count", 32'(instrCount), 32'd1);
`endif

        // cpuHalted stops RUNNING and then blocks a new run press.
        do_reset();
        runPressed = 1'b1;
        cycle();
        runPressed = 1'b0;
        cycle();
        cpuHalted = 1'b1;
        cycle();
        check_eq("halted_stop", 32'(cpuEnable), 32'd0);
        runPressed = 1'b1;
        cycle();
        cycle();
        check_eq("halted_block_ack", 32'(runAck), 32'd1);
        check_eq("halted_block_state", 32'(running), 32'd0);
        runPressed = 1'b0;
        cpuHalted  = 1'b0;
        cycle();

        // All three buttons together from HALTED: all acked, halt wins.
        do_reset();
        {haltPressed, stepPressed, runPressed} = 3'b111;
        cycle();
        check_eq("triple_acks", 32'({haltAck, stepAck, runAck}), 32'd7);
        check_eq("triple_state", 32'(cpuEnable), 32'd0);
        {haltPressed, stepPressed, runPressed} = 3'b000;
        cycle();

        // Counter wrap and clear priority.
        do_reset();
        runPressed = 1'b1;
        cycle();
        runPressed = 1'b0;
        cycleDone  = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
`ifdef FRONT_PANEL_COUNT_EN
        check_eq("count_wrap", 32'(instrCount), 32'd0);
`endif
        for (int i = 0; i < 3; i++) cycle();
        countClear = 1'b1;
        cycle();
`ifdef FRONT_PANEL_COUNT_EN
        check_eq("count_clear", 32'(instrCount), 32'd0);
`endif
        clear_inputs();
        cycle();

        // Reset landing mid-step; a press held through release counts as new.
        stepPressed = 1'b1;
        do_reset();
        stepPressed = 1'b1;
        cycle();
        check_eq("post_reset_step", 32'(cpuEnable), 32'd1);
        do_reset();
        check_eq("mid_step_reset_state", 32'(cpuEnable), 32'd0);
        cycle();
        check_eq("held_press_accept", 32'(cpuEnable), 32'd1);
        clear_inputs();
        cycle();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 3) == 0) runPressed  = ~runPressed;
            if ($urandom_range(0, 3) == 0) stepPressed = ~stepPressed;
            if ($urandom_range(0, 5) == 0) haltPressed = ~haltPressed;
            cycleDone  = ($urandom_range(0, 4) == 0);
            cpuHalted  = ($urandom_range(0, 19) == 0);
            countClear = ($urandom_range(0, 29) == 0);
            if (n % 400 == 399) do_reset();
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/front_panel_control.md
FRONT_PANEL_CONTROL -- requirements
Module: front_panel_control

Interface
REQ-001 Parameter: COUNT_WIDTH, default 16, width of the completed-instruction counter.
REQ-002 Port: clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-high.
REQ-004 Port: runPressed  input  1  debounced run-button press, held high until acknowledged.
REQ-005 Port: stepPressed  input  1  debounced step-button press, held high until acknowledged.
REQ-006 Port: haltPressed  input  1  debounced halt-button press, held high until acknowledged.
REQ-007 Port: cpuHalted  input  1  CPU executed a halt instruction; level, sampled each cycle.
REQ-008 Port: cycleDone  input  1  one-cycle pulse; CPU completed an instruction.
REQ-009 Port: runAck  output  1  acknowledge to the run-button detector.
REQ-010 Port: stepAck  output  1  acknowledge to the step-button detector.
REQ-011 Port: haltAck  output  1  acknowledge to the halt-button detector.
REQ-012 Port: cpuEnable  output  1  CPU may advance while high.
REQ-013 Port: running  output  1  high in RUNNING state; drives the front-panel run lamp.
REQ-014 Port: instrCount  output  COUNT_WIDTH  completed-instruction count (present only with FRONT_PANEL_COUNT_EN).
REQ-015 Port: countClear  input  1  synchronous counter clear (present only with FRONT_PANEL_COUNT_EN).

Function
REQ-016 States SHALL be HALTED, RUNNING, STEPPING; all outputs registered.
REQ-017 A press SHALL be accepted once, on the first cycle its xPressed input is seen high after being low (registered previous-value edge detect).
REQ-018 xAck SHALL go high the cycle after acceptance and stay high until the cycle after xPressed is observed low; every press is acknowledged, including presses the state machine ignores.
REQ-019 Simultaneous accepted presses: halt > step > run; all of them are acknowledged, only the highest-priority one acts.
REQ-020 HALTED: run -> RUNNING; step -> STEPPING; halt ignored; cpuEnable=0.
REQ-021 RUNNING: cpuEnable=1, running=1; halt press or cpuHalted=1 -> HALTED; run and step presses ignored.
REQ-022 STEPPING: cpuEnable=1 until cycleDone sampled high, then -> HALTED with cpuEnable=0 the following cycle; halt press or cpuHalted=1 -> HALTED immediately; run and step presses ignored.
REQ-023 cpuHalted=1 in HALTED SHALL block run and step entry (presses acked, no state change).
REQ-024 Transition latency SHALL be one clock from the accepting cycle to the cpuEnable change.

Reset
REQ-025 Reset SHALL force HALTED, cpuEnable=0, running=0, all acks=0, edge-detect registers=0, instrCount=0, immediately and regardless of clock.
REQ-026 A press held high through reset release SHALL be treated as a new press (previous value reset to 0) and accepted on the first post-reset edge.

Configuration
REQ-027 With FRONT_PANEL_COUNT_EN defined, instrCount SHALL increment by 1 on each cycleDone sampled while cpuEnable=1, wrapping from all-ones to 0; countClear SHALL zero it and take priority over increment.
REQ-028 Without FRONT_PANEL_COUNT_EN, instrCount and countClear SHALL not exist and no counter logic is generated; all other behaviour is unchanged.

Verification
REQ-029 Reset, runPressed held 5 cycles -> RUNNING and cpuEnable=1 one cycle after acceptance; runAck high until one cycle after runPressed falls; exactly one transition.
REQ-030 HALTED, stepPressed, cycleDone pulse 3 cycles later -> cpuEnable high for 4 cycles, then HALTED; instrCount=1.
REQ-031 RUNNING, cpuHalted=1 -> HALTED next cycle; subsequent run press acked, state stays HALTED.
REQ-032 HALTED, run/step/halt asserted same cycle -> all three acked, state remains HALTED (halt wins).
REQ-033 COUNT_WIDTH=4, 16 cycleDone pulses while running -> instrCount wraps 15->0; countClear coincident with cycleDone -> 0.
REQ-034 Reset asserted mid-STEPPING between clock edges -> cpuEnable=0 and acks=0 immediately, without waiting for a clock edge.
